// File: rtl/audio_tone_gen.sv
// Stereo square-wave tone generator with a load/ready note handshake and per-channel volume.
// Optional build macro TONE_GEN_FADE_EN: fades volume in and out with mute instead of cutting it hard.
module audio_tone_gen #(
    parameter int          DIV_W    = 22,
    parameter logic [15:0] AMP_STEP = 16'h0FFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] note_div_left,
    input  logic [DIV_W-1:0] note_div_right,
    input  logic [2:0]       vol,
    input  logic             mute,
    input  logic             load,
    output logic             ready,
    output logic [15:0]      audio_left,
    output logic [15:0]      audio_right
);

    // Index 0 is the left channel, index 1 is the right channel.
    logic [DIV_W-1:0] div_q      [2];
    logic [DIV_W-1:0] cnt_q      [2];
    logic             phase_q    [2];
    logic [2:0]       vol_q      [2];
    logic             pend_q     [2];
    logic [DIV_W-1:0] pend_div_q [2];
    logic [2:0]       pend_vol_q;

    logic [DIV_W-1:0] div_d      [2];
    logic [DIV_W-1:0] cnt_d      [2];
    logic             phase_d    [2];
    logic [2:0]       vol_d      [2];
    logic             pend_d     [2];
    logic [DIV_W-1:0] pend_div_d [2];
    logic [2:0]       pend_vol_d;
    logic             ready_d;

    logic [DIV_W-1:0] note_div [2];
    logic [2:0]       vol_eff  [2];
    logic [15:0]      amp      [2];
    logic [15:0]      sample   [2];
    logic             capture;

    assign capture     = load & ready;
    assign note_div[0] = note_div_left;
    assign note_div[1] = note_div_right;

    // A pending update lands on the first toggle after capture, or straight away on a silent channel.
    always_comb begin
        pend_vol_d = capture ? vol : pend_vol_q;
        for (int ch = 0; ch < 2; ch++) begin
            div_d[ch]      = div_q[ch];
            cnt_d[ch]      = cnt_q[ch];
            phase_d[ch]    = phase_q[ch];
            vol_d[ch]      = vol_q[ch];
            pend_d[ch]     = pend_q[ch];
            pend_div_d[ch] = pend_div_q[ch];

            if (div_q[ch] == '0) begin
                cnt_d[ch]   = '0;
                phase_d[ch] = 1'b0;
                if (pend_q[ch]) begin
                    div_d[ch]   = pend_div_q[ch];
                    vol_d[ch]   = pend_vol_q;
                    phase_d[ch] = (pend_div_q[ch] != '0);
                    pend_d[ch]  = 1'b0;
                end
            end else if (cnt_q[ch] == div_q[ch] - DIV_W'(1)) begin
                cnt_d[ch]   = '0;
                phase_d[ch] = ~phase_q[ch];
                if (pend_q[ch]) begin
                    div_d[ch]  = pend_div_q[ch];
                    vol_d[ch]  = pend_vol_q;
                    pend_d[ch] = 1'b0;
                    if (pend_div_q[ch] == '0)
                        phase_d[ch] = 1'b0;
                end
            end else begin
                cnt_d[ch] = cnt_q[ch] + DIV_W'(1);
            end

            if (capture) begin
                pend_d[ch]     = 1'b1;
                pend_div_d[ch] = note_div[ch];
            end
        end
        ready_d = capture ? 1'b0 : ~(pend_d[0] | pend_d[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                div_q[ch]      <= '0;
                cnt_q[ch]      <= '0;
                phase_q[ch]    <= 1'b0;
                vol_q[ch]      <= '0;
                pend_q[ch]     <= 1'b0;
                pend_div_q[ch] <= '0;
            end
            pend_vol_q <= '0;
            ready      <= 1'b1;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                div_q[ch]      <= div_d[ch];
                cnt_q[ch]      <= cnt_d[ch];
                phase_q[ch]    <= phase_d[ch];
                vol_q[ch]      <= vol_d[ch];
                pend_q[ch]     <= pend_d[ch];
                pend_div_q[ch] <= pend_div_d[ch];
            end
            pend_vol_q <= pend_vol_d;
            ready      <= ready_d;
        end
    end

`ifdef TONE_GEN_FADE_EN
    logic [15:0] presc_q;
    logic [2:0]  fade_q   [2];
    logic [2:0]  fade_tgt [2];

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            fade_tgt[ch] = mute ? 3'd0 : vol_q[ch];
            vol_eff[ch]  = fade_q[ch];
        end
    end

    // Effective volume creeps one level per prescaler wrap toward the mute-dependent target.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            fade_q[0] <= '0;
            fade_q[1] <= '0;
        end else begin
            presc_q <= presc_q + 16'd1;
            if (presc_q == 16'hFFFF) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (fade_q[ch] < fade_tgt[ch])
                        fade_q[ch] <= fade_q[ch] + 3'd1;
                    else if (fade_q[ch] > fade_tgt[ch])
                        fade_q[ch] <= fade_q[ch] - 3'd1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int ch = 0; ch < 2; ch++)
            vol_eff[ch] = mute ? 3'd0 : vol_q[ch];
    end
`endif

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            amp[ch] = AMP_STEP * {13'd0, vol_eff[ch]};
            if (div_q[ch] == '0 || vol_eff[ch] == 3'd0)
                sample[ch] = 16'h0000;
            else if (phase_q[ch])
                sample[ch] = amp[ch];
            else
                sample[ch] = ~amp[ch] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            audio_left  <= 16'h0000;
            audio_right <= 16'h0000;
        end else begin
            audio_left  <= sample[0];
            audio_right <= sample[1];
        end
    end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Scoreboard bench for audio_tone_gen: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_audio_tone_gen;

    localparam int DIV_W = 22;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] note_div_left = '0;
    logic [DIV_W-1:0] note_div_right = '0;
    logic [2:0]       vol = '0;
    logic             mute = 1'b0;
    logic             load = 1'b0;
    logic             ready;
    logic [15:0]      audio_left;
    logic [15:0]      audio_right;

    audio_tone_gen #(.DIV_W(DIV_W), .AMP_STEP(16'h0FFF)) dut (
        .clk           (clk),
        .rst           (rst),
        .note_div_left (note_div_left),
        .note_div_right(note_div_right),
        .vol           (vol),
        .mute          (mute),
        .load          (load),
        .ready         (ready),
        .audio_left    (audio_left),
        .audio_right   (audio_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] l;
        logic [15:0] r;
        logic        rdy;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   c;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, compare all expectations scheduled for the last edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("[TB] FAIL %s missed: checked at cycle %0d, required cycle %0d", e.tag, cyc, e.cyc);
            end else begin
                if (audio_left !== e.l) begin
                    n_bad++;
                    $display("[TB] FAIL %s audio_left @%0d: got %h want %h", e.tag, cyc, audio_left, e.l);
                end
                n_cmp++;
                if (audio_right !== e.r) begin
                    n_bad++;
                    $display("[TB] FAIL %s audio_right @%0d: got %h want %h", e.tag, cyc, audio_right, e.r);
                end
                n_cmp++;
                if (ready !== e.rdy) begin
                    n_bad++;
                    $display("[TB] FAIL %s ready @%0d: got %b want %b", e.tag, cyc, ready, e.rdy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after edge e-1 so that inputs set next are sampled at edge e.
    task automatic gotoEdge(input int edge_n);
        while (cyc < edge_n - 1) tick();
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input int dl, input int dr,
                                 input int v, input logic m);
        rst            = r;
        load           = ld;
        note_div_left  = DIV_W'(dl);
        note_div_right = DIV_W'(dr);
        vol            = 3'(v);
        mute           = m;
    endtask

    task automatic checkOutput(input int at, input logic [15:0] l, input logic [15:0] r,
                               input logic rdy, input string tag);
        exp_t x;
        x.cyc = at;
        x.l   = l;
        x.r   = r;
        x.rdy = rdy;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        checkOutput(cyc, 16'h0000, 16'h0000, 1'b1, "reset");
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [15:0] expLeft12(input int k);
        if (k < 2)        return 16'h0000;
        else if (k < 6)   return 16'h0FFF;
        else if (k < 10)  return 16'hF001;
        else if (k < 14)  return 16'h0FFF;
        else if (k < 20)  return 16'hF001;
        else if (k < 26)  return 16'h0FFF;
        else              return 16'hF001;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Basic tone, then a mid-half-period retune and an ignored load while busy.
        doReset();
        c = cyc + 1;
        for (int k = 0; k < 28; k++)
            checkOutput(c + k, expLeft12(k), 16'h0000,
                        (k == 0 || k == 11 || k == 12) ? 1'b0 : 1'b1, "tone_retune");
        applyStimulus(1'b0, 1'b1, 4, 0, 1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4, 0, 1, 1'b0);
        gotoEdge(c + 11);
        applyStimulus(1'b0, 1'b1, 6, 0, 1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 9, 0, 1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 9, 0, 1, 1'b0);
        drain();

        // Full volume at div=1 on both channels, with a mute window in the middle.
        doReset();
        c = cyc + 1;
        for (int k = 0; k < 16; k++) begin
            logic [15:0] s;
            if (k < 2 || (k >= 10 && k <= 12)) s = 16'h0000;
            else s = (k % 2 == 0) ? 16'h6FF9 : 16'h9007;
            checkOutput(c + k, s, s, (k == 0) ? 1'b0 : 1'b1, "div1_mute");
        end
        applyStimulus(1'b0, 1'b1, 1, 1, 7, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1, 1, 7, 1'b0);
        gotoEdge(c + 10);
        mute = 1'b1;
        gotoEdge(c + 13);
        mute = 1'b0;
        drain();

        // Reset while an update is pending, then a fresh load afterwards.
        doReset();
        c = cyc + 1;
        checkOutput(c + 0, 16'h0000, 16'h0000, 1'b0, "rst_pend");
        checkOutput(c + 1, 16'h0000, 16'h0000, 1'b1, "rst_pend");
        checkOutput(c + 2, 16'h1FFE, 16'h1FFE, 1'b1, "rst_pend");
        checkOutput(c + 3, 16'h1FFE, 16'h1FFE, 1'b0, "rst_pend");
        checkOutput(c + 4, 16'h1FFE, 16'h1FFE, 1'b0, "rst_pend");
        checkOutput(c + 5, 16'h0000, 16'h0000, 1'b1, "rst_pend");
        checkOutput(c + 6, 16'h0000, 16'h0000, 1'b1, "rst_pend");
        checkOutput(c + 7, 16'h0000, 16'h0000, 1'b1, "rst_pend");
        checkOutput(c + 8, 16'h0000, 16'h0000, 1'b0, "rst_pend");
        checkOutput(c + 9, 16'h0000, 16'h0000, 1'b1, "rst_pend");
        for (int k = 10; k < 16; k++)
            checkOutput(c + k, (k < 13) ? 16'h0FFF : 16'hF001, 16'h0000, 1'b1, "rst_pend");
        applyStimulus(1'b0, 1'b1, 8, 8, 2, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8, 8, 2, 1'b0);
        gotoEdge(c + 3);
        applyStimulus(1'b0, 1'b1, 2, 2, 3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2, 2, 3, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gotoEdge(c + 8);
        applyStimulus(1'b0, 1'b1, 3, 0, 1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 3, 0, 1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_tone_gen.md
AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

Interface
REQ-001 Parameter DIV_W, default 22: width of the half-period divider inputs, in clk cycles.
REQ-002 Parameter AMP_STEP, default 16'h0FFF: amplitude added per volume level.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 note_div_left  in  DIV_W  left half-period in clk cycles; 0 = silence.
REQ-006 note_div_right  in  DIV_W  right half-period in clk cycles; 0 = silence.
REQ-007 vol  in  3  volume level 0..7.
REQ-008 mute  in  1  level-sensitive output mute.
REQ-009 load  in  1  request to capture note_div_left, note_div_right and vol.
REQ-010 ready  out  1  high = load is accepted this cycle.
REQ-011 audio_left  out  16  signed two's-complement sample, feeds the speaker serializer left input.
REQ-012 audio_right  out  16  signed two's-complement sample, feeds the speaker serializer right input.

Function
REQ-013 The handshake SHALL accept when load=1 and ready=1: the inputs are captured into pending registers and ready drops to 0 on the next cycle.
REQ-014 A load with ready=0 SHALL be ignored; the pending registers SHALL stay unchanged.
REQ-015 Each channel SHALL hold an active divider div, a counter cnt (0..div-1), a phase bit and an active volume.
REQ-016 With div>0, cnt SHALL increment each cycle; at cnt==div-1 a toggle event occurs: phase inverts and cnt returns to 0.
REQ-017 div=1 SHALL toggle phase every cycle.
REQ-018 A pending channel update SHALL apply at that channel's first toggle event strictly after capture; the update is div<=pending div, vol<=pending vol, cnt<=0, and phase inverts as normal.
REQ-019 A pending update to a channel whose active div==0 SHALL apply on the cycle after capture, with cnt<=0 and phase<=1.
REQ-020 Applying div=0 SHALL silence the channel: cnt is held at 0, phase<=0 and the output is 0.
REQ-021 ready SHALL return to 1 on the cycle after both channels have applied; left and right apply independently.
REQ-022 A toggle event coinciding with capture SHALL NOT apply the new values; it is a normal toggle.
REQ-023 Amplitude is amp = vol_eff * AMP_STEP in 16-bit arithmetic; vol_eff=7 gives 16'h6FF9, with no overflow.
REQ-024 The registered output SHALL be +amp when phase=1, -amp (two's complement) when phase=0, and 0 when div==0 or vol_eff==0.
REQ-025 Output latency SHALL be one cycle from any phase or vol_eff change to audio_left/audio_right.
REQ-026 mute SHALL NOT stop counters or phase, so that waveform continuity is preserved on unmute.

Reset
REQ-027 With rst=1 at a clock edge: all div, cnt, phase, vol and pending registers <=0; ready<=1; audio_left=audio_right=16'h0000 on the next cycle.
REQ-028 rst mid-operation SHALL discard any pending update; the first load after rst releases is accepted normally.

Configuration
REQ-029 Macro TONE_GEN_FADE_EN, when defined: a per-block 16-bit prescaler SHALL step vol_eff by one level every 65536 cycles, down toward 0 while mute=1 and up toward the active vol while mute=0.
REQ-030 When TONE_GEN_FADE_EN is undefined: vol_eff = mute ? 0 : active vol, so mute forces both outputs to 0 on the cycle after mute rises.

Verification
REQ-031 rst, then load with div_l=4, div_r=0, vol=1 -> ready low for 1-2 cycles; audio_left alternates +16'h0FFF / 16'hF001 every 4 cycles; audio_right stays 0.
REQ-032 Running div_l=4, then load div_l=6 mid-half-period -> the current half-period completes at 4 cycles, the following ones are 6 cycles, and ready returns 1 after both channels apply.
REQ-033 Second load asserted while ready=0 with div_l=9 -> ignored; period unchanged; pending value unchanged.
REQ-034 vol=7, div_l=div_r=1 -> both outputs alternate 16'h6FF9 / 16'h9007 every cycle.
REQ-035 mute=1 without TONE_GEN_FADE_EN -> outputs 16'h0000 on the next cycle; counters keep running; unmute resumes with the correct phase.
REQ-036 rst pulsed while an update is pending -> the next cycle shows ready=1 and outputs 0; the pending update is never applied.
